// File: rtl/spi_master.sv
// SPI mode-0 master: SSEL setup, BUFFER_SIZE-bit MSB-first exchange, SSEL hold, then an inter-frame gap.
// done fires 2*CS_SETUP + 2*BUFFER_SIZE*CLK_DIV cycles after SSEL falls; start is ignored while busy.
module spi_master #(
    parameter int BUFFER_SIZE = 240,
    parameter int CLK_DIV     = 4,
    parameter int CS_SETUP    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   busy,
    output logic                   done,
    output logic                   SPI_SCK,
    output logic                   SPI_SSEL,
    output logic                   SPI_MOSI,
    input  logic                   SPI_MISO
);

    localparam int BIT_CYC = 2 * CLK_DIV - 1;
    localparam int CNT_MAX = (BIT_CYC > CS_SETUP - 1) ? BIT_CYC : CS_SETUP - 1;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    // The IDLE cycle that samples the next start completes the SSEL-high gap.
    localparam int GAP_LEN = (CS_SETUP > 1) ? CS_SETUP - 1 : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] LOW_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PER_LAST   = CW'(BIT_CYC);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(BUFFER_SIZE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_q;
    logic [BUFFER_SIZE-1:0] sr_q;
    logic [BUFFER_SIZE-1:0] rx_q;
    logic                   sck_q;
    logic                   ssel_q;
    logic                   mosi_q;
    logic                   busy_q;
    logic                   done_q;

    assign rx_data  = rx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign SPI_SCK  = sck_q;
    assign SPI_SSEL = ssel_q;
    assign SPI_MOSI = mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            ssel_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= tx_data;
                        mosi_q  <= tx_data[BUFFER_SIZE-1];
                        ssel_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                XFER: begin
                    // Rising edge samples MISO; after the shift sr_q[MSB] is the next bit to drive.
                    if (cnt_q == LOW_LAST) begin
                        sck_q <= 1'b1;
                        sr_q  <= {sr_q[BUFFER_SIZE-2:0], SPI_MISO};
                    end
                    if (cnt_q == PER_LAST) begin
                        sck_q <= 1'b0;
                        cnt_q <= '0;
                        if (bit_q == LAST_BIT) begin
                            state_q <= HOLD;
                        end else begin
                            bit_q  <= bit_q + BW'(1);
                            mosi_q <= sr_q[BUFFER_SIZE-1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == SETUP_LAST) begin
                        ssel_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rx_q    <= sr_q;
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 16-bit instance with loopback/tied MISO and a default-size instance with a slave model.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tx_data = '0;
    logic [15:0] rx_data;
    logic        busy, done, sck, ssel, mosi, miso;
    logic [1:0]  miso_sel = 2'd0;

    logic         start2 = 1'b0;
    logic [239:0] tx2 = '0;
    logic [239:0] rx2;
    logic         busy2, done2, sck2, ssel2, mosi2, miso2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign miso = (miso_sel == 2'd2) ? mosi : miso_sel[0];

    spi_master #(.BUFFER_SIZE(16), .CLK_DIV(2), .CS_SETUP(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .rx_data(rx_data),
        .busy(busy), .done(done), .SPI_SCK(sck), .SPI_SSEL(ssel), .SPI_MOSI(mosi), .SPI_MISO(miso)
    );

    spi_master dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx2), .rx_data(rx2),
        .busy(busy2), .done(done2), .SPI_SCK(sck2), .SPI_SSEL(ssel2), .SPI_MOSI(mosi2), .SPI_MISO(miso2)
    );

    // Cumulative observations of the 16-bit instance; tests snapshot and difference them.
    int cyc = 0, done_cnt = 0, fall_cyc = 0, done_cyc = 0;
    int low_run = 0, last_low = 0, high_run = 0, last_high = 0;
    int rx_bad = 0, sck_bad = 0, mosi_ones = 0, sck_rises = 0;
    logic        prev_ssel = 1'b1;
    logic [15:0] prev_rx = '0;
    logic [15:0] mosi_cap = '0;

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!ssel) begin
            if (prev_ssel) begin
                fall_cyc  = cyc;
                last_high = high_run;
                high_run  = 0;
            end
            low_run++;
            if (mosi) mosi_ones++;
        end else begin
            if (!prev_ssel) begin
                last_low = low_run;
                low_run  = 0;
            end
            high_run++;
        end
        if (ssel && sck) sck_bad++;
        if (rst_n && !done && rx_data !== prev_rx) rx_bad++;
        prev_rx   = rx_data;
        prev_ssel = ssel;
    end

    always @(posedge sck) begin
        sck_rises++;
        mosi_cap = {mosi_cap[14:0], mosi};
    end

    // Slave for the default-size instance: presents bit k of slave_frame before the k-th SCK rise.
    logic [239:0] slave_frame = '0;
    int sck2_rises = 0, base2 = 0, k2;
    int low2 = 0, last_low2 = 0;
    logic prev_ssel2 = 1'b1;

    always @(posedge sck2) sck2_rises++;
    always @(negedge ssel2) base2 = sck2_rises;

    always_comb begin
        k2 = sck2_rises - base2;
        miso2 = 1'b0;
        if (k2 >= 0 && k2 < 240) miso2 = slave_frame[239 - k2];
    end

    always @(negedge clk) begin
        if (!ssel2) low2++;
        else if (!prev_ssel2) begin
            last_low2 = low2;
            low2 = 0;
        end
        prev_ssel2 = ssel2;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (ssel !== 1'b1) $display("FAIL reset_ssel got=%b exp=1", ssel); else passes++;
        checks++; if (sck !== 1'b0) $display("FAIL reset_sck got=%b exp=0", sck); else passes++;
        checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", mosi); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
        checks++; if (rx_data !== 16'h0000) $display("FAIL reset_rx got=%h exp=0000", rx_data); else passes++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_loopback();
        bit ok;
        int r;
        miso_sel = 2'd2;
        tx_data  = 16'hA55A;
        r = sck_rises;
        pulse_start();
        checks++; if (ssel !== 1'b0 || busy !== 1'b1) $display("FAIL lb_setup ssel=%b busy=%b exp ssel=0 busy=1", ssel, busy); else passes++;
        checks++; if (mosi !== 1'b1) $display("FAIL lb_setup_mosi got=%b exp=1", mosi); else passes++;
        wait_done(200, ok);
        checks++; if (!ok) $display("FAIL lb_done_timeout got=none exp=done"); else passes++;
        checks++; if (done_cyc - fall_cyc !== 68) $display("FAIL lb_done_latency got=%0d exp=68", done_cyc - fall_cyc); else passes++;
        checks++; if (last_low !== 68) $display("FAIL lb_ssel_low got=%0d exp=68", last_low); else passes++;
        checks++; if (rx_data !== 16'hA55A) $display("FAIL lb_rx got=%h exp=a55a", rx_data); else passes++;
        checks++; if (sck_rises - r !== 16) $display("FAIL lb_sck_rises got=%0d exp=16", sck_rises - r); else passes++;
        checks++; if (mosi_cap !== 16'hA55A) $display("FAIL lb_mosi got=%h exp=a55a", mosi_cap); else passes++;
        checks++; if (mosi !== 1'b0 || busy !== 1'b1) $display("FAIL lb_done_cycle mosi=%b busy=%b exp mosi=0 busy=1", mosi, busy); else passes++;
        tick(1);
        checks++; if (done !== 1'b0) $display("FAIL lb_done_width got=%b exp=0", done); else passes++;
        tick(3);
        checks++; if (busy !== 1'b0) $display("FAIL lb_idle_busy got=%b exp=0", busy); else passes++;
    endtask

    task automatic test_miso_const();
        bit ok;
        int m;
        miso_sel = 2'd1;
        tx_data  = 16'h0000;
        m = mosi_ones;
        pulse_start();
        wait_done(200, ok);
        checks++; if (!ok) $display("FAIL one_done_timeout got=none exp=done"); else passes++;
        checks++; if (rx_data !== 16'hFFFF) $display("FAIL one_rx got=%h exp=ffff", rx_data); else passes++;
        checks++; if (mosi_ones - m !== 0) $display("FAIL zero_mosi_high got=%0d exp=0", mosi_ones - m); else passes++;
        tick(3);
        miso_sel = 2'd0;
        tx_data  = 16'hFFFF;
        pulse_start();
        wait_done(200, ok);
        checks++; if (!ok) $display("FAIL zero_done_timeout got=none exp=done"); else passes++;
        checks++; if (rx_data !== 16'h0000) $display("FAIL zero_rx got=%h exp=0000", rx_data); else passes++;
        checks++; if (mosi_cap !== 16'hFFFF) $display("FAIL ones_mosi got=%h exp=ffff", mosi_cap); else passes++;
        tick(3);
    endtask

    task automatic test_ignore();
        bit ok;
        int d;
        miso_sel = 2'd2;
        tx_data  = 16'h3C96;
        d = done_cnt;
        pulse_start();
        tick(20);
        tx_data = 16'hFFFF;
        pulse_start();
        wait_done(200, ok);
        checks++; if (!ok) $display("FAIL ign_done_timeout got=none exp=done"); else passes++;
        pulse_start();
        tick(100);
        checks++; if (done_cnt - d !== 1) $display("FAIL ign_done_count got=%0d exp=1", done_cnt - d); else passes++;
        checks++; if (rx_data !== 16'h3C96) $display("FAIL ign_rx got=%h exp=3c96", rx_data); else passes++;
        checks++; if (mosi_cap !== 16'h3C96) $display("FAIL ign_mosi got=%h exp=3c96", mosi_cap); else passes++;
        checks++; if (busy !== 1'b0 || ssel !== 1'b1) $display("FAIL ign_idle busy=%b ssel=%b exp busy=0 ssel=1", busy, ssel); else passes++;
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        int d, rb;
        logic [15:0] rxa, rxb, rxc;
        miso_sel = 2'd2;
        tx_data  = 16'h0F0F;
        d  = done_cnt;
        rb = rx_bad;
        start = 1'b1;
        wait_done(200, ok1);
        rxa = rx_data;
        tx_data = 16'hF00F;
        tick(1);
        wait_done(200, ok2);
        rxb = rx_data;
        tx_data = 16'h8001;
        tick(1);
        wait_done(200, ok3);
        rxc = rx_data;
        start = 1'b0;
        checks++; if (!(ok1 && ok2 && ok3)) $display("FAIL b2b_timeout got=%b%b%b exp=111", ok1, ok2, ok3); else passes++;
        checks++; if (last_high !== 2) $display("FAIL b2b_ssel_gap got=%0d exp=2", last_high); else passes++;
        tick(100);
        checks++; if (done_cnt - d !== 3) $display("FAIL b2b_done_count got=%0d exp=3", done_cnt - d); else passes++;
        checks++; if (rxa !== 16'h0F0F) $display("FAIL b2b_rx1 got=%h exp=0f0f", rxa); else passes++;
        checks++; if (rxb !== 16'hF00F) $display("FAIL b2b_rx2 got=%h exp=f00f", rxb); else passes++;
        checks++; if (rxc !== 16'h8001) $display("FAIL b2b_rx3 got=%h exp=8001", rxc); else passes++;
        checks++; if (rx_bad - rb !== 0) $display("FAIL b2b_rx_outside_done got=%0d exp=0", rx_bad - rb); else passes++;
        checks++; if (sck_bad !== 0) $display("FAIL sck_high_while_deselected got=%0d exp=0", sck_bad); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r, d;
        miso_sel = 2'd2;
        tx_data  = 16'hBEEF;
        r = sck_rises;
        d = done_cnt;
        pulse_start();
        for (int i = 0; i < 100 && (sck_rises - r) < 8; i++) tick(1);
        checks++; if (sck_rises - r !== 8) $display("FAIL rst_reach_bit7 got=%0d exp=8", sck_rises - r); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (ssel !== 1'b1 || sck !== 1'b0) $display("FAIL rst_mid_pins ssel=%b sck=%b exp ssel=1 sck=0", ssel, sck); else passes++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_flags busy=%b done=%b exp=0,0", busy, done); else passes++;
        checks++; if (rx_data !== 16'h0000 || mosi !== 1'b0) $display("FAIL rst_mid_data rx=%h mosi=%b exp=0000,0", rx_data, mosi); else passes++;
        tick(2);
        rst_n = 1'b1;
        tick(100);
        checks++; if (done_cnt - d !== 0) $display("FAIL rst_no_done got=%0d exp=0", done_cnt - d); else passes++;
        tx_data = 16'h1234;
        pulse_start();
        wait_done(200, ok);
        checks++; if (!ok) $display("FAIL rst_next_timeout got=none exp=done"); else passes++;
        checks++; if (rx_data !== 16'h1234) $display("FAIL rst_next_rx got=%h exp=1234", rx_data); else passes++;
        tick(5);
    endtask

    task automatic test_defaults();
        bit ok;
        int r;
        logic [31:0]  hdr;
        logic [207:0] tail;
        hdr  = 32'h64617461;
        tail = {26{8'hA5}};
        // Slave emits the header word least-significant byte first, each byte MSB first.
        slave_frame = {hdr[7:0], hdr[15:8], hdr[23:16], hdr[31:24], tail};
        tx2 = {15{16'hC3A5}};
        r = sck2_rises;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick(1);
            if (done2) ok = 1'b1;
        end
        checks++; if (!ok) $display("FAIL def_done_timeout got=none exp=done"); else passes++;
        checks++; if (last_low2 !== 1924) $display("FAIL def_ssel_low got=%0d exp=1924", last_low2); else passes++;
        checks++; if (sck2_rises - r !== 240) $display("FAIL def_sck_rises got=%0d exp=240", sck2_rises - r); else passes++;
        checks++; if (rx2[239:208] !== 32'h61746164) $display("FAIL def_header got=%h exp=61746164", rx2[239:208]); else passes++;
        checks++; if (rx2[207:0] !== tail) $display("FAIL def_payload got=%h exp=%h", rx2[207:0], tail); else passes++;
        tick(5);
        checks++; if (busy2 !== 1'b0) $display("FAIL def_idle_busy got=%b exp=0", busy2); else passes++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_const();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_defaults();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 240, meaning bits per frame (>=8).
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCK half-period (>=1).
REQ-003 SHALL have parameter CS_SETUP, default 2, meaning clk cycles of SSEL setup, hold and inter-frame gap (>=1).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one frame; sampled only in IDLE.
REQ-007 tx_data  input  BUFFER_SIZE  frame to send, latched at accepted start.
REQ-008 rx_data  output  BUFFER_SIZE  last complete received frame.
REQ-009 busy  output  1  high from cycle after accepted start until end of gap.
REQ-010 done  output  1  one-cycle pulse when rx_data updates.
REQ-011 SPI_SCK  output  1  serial clock, mode 0 (idle low).
REQ-012 SPI_SSEL  output  1  active-low chip select.
REQ-013 SPI_MOSI  output  1  serial data out, MSB first.
REQ-014 SPI_MISO  input  1  serial data in, MSB first.

Function
REQ-015 SHALL implement states IDLE, SETUP, XFER, HOLD, GAP.
REQ-016 IDLE: SSEL=1, SCK=0, MOSI=0, busy=0; start=1 -> latch tx_data into shift register, go SETUP.
REQ-017 SETUP: SSEL=0, busy=1, MOSI=tx_data[BUFFER_SIZE-1]; lasts exactly CS_SETUP cycles, then XFER.
REQ-018 XFER: BUFFER_SIZE bit periods, each = CLK_DIV cycles SCK low then CLK_DIV cycles SCK high; total 2*BUFFER_SIZE*CLK_DIV cycles.
REQ-019 On each SCK rising edge: MISO sampled into shift register LSB, register shifted left.
REQ-020 On each SCK falling edge except the last: MOSI updated to next bit (tx_data[BUFFER_SIZE-1-n] during bit n).
REQ-021 After final SCK falling edge (SCK=0): go HOLD; MOSI holds last bit, SSEL stays 0 for CS_SETUP cycles.
REQ-022 HOLD exit cycle: SSEL=1, rx_data = received frame (first received bit at rx_data[BUFFER_SIZE-1]), done=1 for exactly that cycle, MOSI=0; go GAP.
REQ-023 GAP: SSEL=1, busy=1 for CS_SETUP cycles, then IDLE (busy=0).
REQ-024 SSEL fall to SSEL rise SHALL be exactly CS_SETUP + 2*BUFFER_SIZE*CLK_DIV + CS_SETUP cycles.
REQ-025 start while busy=1 SHALL be ignored (not queued); start held high in IDLE launches back-to-back frames separated by GAP.
REQ-026 tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-027 rx_data SHALL change only at done; it holds its value across frames otherwise.
REQ-028 Exactly BUFFER_SIZE SCK rising edges per frame; SCK SHALL be 0 whenever SSEL=1.
REQ-029 All outputs SHALL be registered (no combinational path from MISO or start to outputs).

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE: SSEL=1, SCK=0, MOSI=0, busy=0, done=0, rx_data=0, counters=0.
REQ-031 Reset mid-frame SHALL abort without done pulse; first start after rst_n rises SHALL yield a complete, correct frame.

Verification (bench parameters BUFFER_SIZE=16, CLK_DIV=2, CS_SETUP=2 unless stated)
REQ-032 Loopback MOSI->MISO, tx_data=16'hA55A, start pulse -> 16 SCK rises, done 68 cycles after SSEL fall, rx_data=16'hA55A.
REQ-033 MISO tied 1, tx_data=16'h0000 -> MOSI constant 0, rx_data=16'hFFFF; MISO tied 0 -> rx_data=16'h0000.
REQ-034 Second start pulses during XFER and GAP -> ignored, single done; tx_data changed mid-frame -> MOSI still carries original value.
REQ-035 start held high 3 frames -> 3 done pulses, SSEL high exactly 2 cycles between frames, rx_data updates only at done.
REQ-036 rst_n asserted at bit 7 of XFER -> SSEL=1, SCK=0, busy=0 same cycle, no done, rx_data=0; next frame 16'h1234 loopback -> 16'h1234.
REQ-037 Defaults (240/4/2), slave model returning header 0x64617461 in first 32 bits -> rx_data[239:208]=32'h61746164 byte order as shifted, frame length 1924 cycles SSEL low.
